// File: rtl/bitop_stream_pkg.sv
// bitop_stream_pkg: op encoding, width-generic fold helper and counter width for bitop_stream_pipe
package bitop_stream_pkg;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_e;
    localparam int CNT_W = 32;
    localparam int FOLD_MAX_W = 64;
    localparam int FOLD_IN_W = 2 * FOLD_MAX_W;
    function automatic logic [FOLD_MAX_W-1:0] fold(input logic [FOLD_IN_W-1:0] x, input int w);
        fold = '0;
        for (int i = 0; i < FOLD_MAX_W; i++)
            if (i < w) fold[6'(i)] = x[7'(i)] ^ x[7'(i + w)];
    endfunction
endpackage

// File: rtl/bitop_unit.sv
// bitop_unit: combinational AND/OR/XOR/NAND selected by op_e
module bitop_unit
    import bitop_stream_pkg::*;
#(
    parameter int BITWIDTH = 16
) (
    input  op_e                 op,
    input  logic [BITWIDTH-1:0] x,
    input  logic [BITWIDTH-1:0] y,
    output logic [BITWIDTH-1:0] z
);
    always_comb
        z = op == OP_AND ? x & y :
            op == OP_OR  ? x | y :
            op == OP_XOR ? x ^ y : ~(x & y);
endmodule

// File: rtl/bitop_stream_pipe.sv
// bitop_stream_pipe: handshaked square/fold/bitop pipeline; BITOP_PERF_CNT_EN adds txn/stall counters
module bitop_stream_pipe
    import bitop_stream_pkg::*;
#(
    parameter int BITWIDTH            = 16,
    parameter int NUM_PIPELINE_STAGES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic [1:0]          op_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] result
`ifdef BITOP_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    txn_count,
    output logic [CNT_W-1:0]    stall_count
`endif
);
    localparam int NS = NUM_PIPELINE_STAGES;
    localparam int PW = 2 * BITWIDTH;
    logic [NS-1:0]               r_iv;
    logic [NS-1:0][BITWIDTH-1:0] r_ia;
    logic [NS-1:0][BITWIDTH-1:0] r_ib;
    logic [NS-1:0][1:0]          r_iop;
    logic                        r_sv;
    logic [PW-1:0]               r_sa;
    logic [PW-1:0]               r_sb;
    op_e                         r_sop;
    logic                        r_fv;
    logic [BITWIDTH-1:0]         r_fa;
    logic [BITWIDTH-1:0]         r_fb;
    op_e                         r_fop;
    logic [NS-1:0]               r_ov;
    logic [NS-1:0][BITWIDTH-1:0] r_or;
    logic                        w_adv;
    logic [BITWIDTH-1:0]         w_op;
    assign w_adv     = !r_ov[NS-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_ov[NS-1];
    assign result    = r_or[NS-1];
    bitop_unit #(.BITWIDTH(BITWIDTH)) u_op (.op(r_fop), .x(r_fa), .y(r_fb), .z(w_op));
    // every stage shifts together on w_adv, so a stall freezes the whole pipe
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_iv  <= '0;
            r_ia  <= '0;
            r_ib  <= '0;
            r_iop <= '0;
            r_sv  <= 1'b0;
            r_sa  <= '0;
            r_sb  <= '0;
            r_sop <= OP_AND;
            r_fv  <= 1'b0;
            r_fa  <= '0;
            r_fb  <= '0;
            r_fop <= OP_AND;
            r_ov  <= '0;
            r_or  <= '0;
        end else if (w_adv) begin
            r_iv  <= NS'({r_iv, in_valid});
            r_ia  <= (NS*BITWIDTH)'({r_ia, a});
            r_ib  <= (NS*BITWIDTH)'({r_ib, b});
            r_iop <= (NS*2)'({r_iop, op_sel});
            r_sv  <= r_iv[NS-1];
            r_sa  <= PW'(r_ia[NS-1]) * PW'(r_ia[NS-1]);
            r_sb  <= PW'(r_ib[NS-1]) * PW'(r_ib[NS-1]);
            r_sop <= op_e'(r_iop[NS-1]);
            r_fv  <= r_sv;
            r_fa  <= BITWIDTH'(fold(FOLD_IN_W'(r_sa), BITWIDTH));
            r_fb  <= BITWIDTH'(fold(FOLD_IN_W'(r_sb), BITWIDTH));
            r_fop <= r_sop;
            r_ov  <= NS'({r_ov, r_fv});
            r_or  <= (NS*BITWIDTH)'({r_or, w_op});
        end
`ifdef BITOP_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            txn_count   <= '0;
            stall_count <= '0;
        end else begin
            if (out_valid && out_ready) txn_count <= txn_count + CNT_W'(1);
            if (out_valid && !out_ready) stall_count <= stall_count + CNT_W'(1);
        end
`endif
endmodule
